sram_pixel_reader: RTL and testbench
====================================

Name: sram_pixel_reader

Overview:
Read-stream stage directly upstream of sram_iface. It accepts a block-read command of base address plus word count, and issues one read per word through sram_iface's start/io_done handshake. Each returned 32-bit word is unpacked into 8-bit pixels on a valid/ready stream for the edge-detector datapath.

Parameters:
ADDR_W, 16, SRAM word-address width (matches sram_iface i_address)
DATA_W, 32, SRAM data width (matches sram_iface i_r_data)
PIX_W, 8, pixel width; DATA_W must be an integer multiple of PIX_W
ADDR_STEP, 1, address increment per word read

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset; asynchronous, active-high (1 = reset)
cmd_start  in  1  one-cycle command strobe
cmd_base_addr  in  ADDR_W  first word address
cmd_num_words  in  16  number of words to read
busy  out  1  high from accepted command until done
done  out  1  one-cycle pulse when the last pixel is accepted, or immediately for a zero-length command
iface_start  out  1  read request strobe to sram_iface start
iface_writemode  out  1  tied to 0 (read)
iface_address  out  ADDR_W  to sram_iface i_address
iface_r_data  in  DATA_W  from sram_iface i_r_data
iface_io_done  in  1  sram_iface completion strobe
pix_data  out  PIX_W  pixel output
pix_valid  out  1  pixel valid
pix_ready  in  1  downstream ready
pix_last  out  1  high with the final pixel of the command

Behaviour:
- Reset: all outputs 0 (busy, done, iface_start, iface_address, pix_data, pix_valid, pix_last). FSM to IDLE, counters cleared. Reset takes effect mid-operation with no completion; a late iface_io_done is ignored in IDLE.
- Registered outputs only; iface_writemode is constant 0.
- States:
  - IDLE: on cmd_start, latch base address and count; set busy. If count == 0, pulse done next cycle and return to IDLE; otherwise go to REQ.
  - REQ: drive iface_start=1 for exactly one cycle with iface_address = current address; go to WAIT. Latency is cmd_start at edge N to iface_start high after edge N+1.
  - WAIT: hold iface_address stable. On iface_io_done, capture iface_r_data into the word register and go to UNPACK.
  - UNPACK: emit DATA_W/PIX_W pixels, least-significant byte first (bits[7:0], then [15:8], ...).
    - A pixel transfers on a clk edge with pix_valid && pix_ready.
    - pix_data and pix_valid hold stable while pix_ready is low; pix_valid is never dropped without a transfer.
    - After the last pixel of a word: decrement the remaining count and add ADDR_STEP to the address (modulo 2^ADDR_W; 0xFFFF wraps to 0x0000). Go to REQ, or to IDLE if the count is exhausted.
- pix_last is high only on the final pixel of the final word.
- done pulses on the cycle after the final transfer; busy falls the same cycle.
- cmd_start while busy is ignored; the latched command is not modified.
- iface_io_done outside WAIT is ignored.

Optional Feature:
Macro PIX_PREFETCH_EN.
- Defined:
  - Adds one DATA_W holding register.
  - While UNPACK drains the current word, the next read is issued (REQ/WAIT run concurrently with UNPACK) when words remain and the holding register is empty.
  - At a word boundary, the held word moves to the unpack register with no bubble, so pix_valid stays high across words if pix_ready stays high.
  - Pixel order, address order, pix_last and done timing rules are unchanged.
  - At most one outstanding read.
- Undefined: strictly sequential REQ -> WAIT -> UNPACK per word as above, with no holding register.

Test Plan:
1. Reset during WAIT (addr 0x0010) with an iface_io_done one cycle later -> all outputs 0, FSM IDLE, no pixel emitted, busy stays 0.
2. cmd_base_addr=0x0001, num_words=1, SRAM word 0x000000AF, pix_ready=1 -> one iface_start with address 0x0001; pixels 0xAF,0x00,0x00,0x00; pix_last on the 4th; done 1 cycle later.
3. cmd_base_addr=0xFFFF, num_words=2, words 0x44332211 and 0x88776655 -> reads at 0xFFFF then 0x0000; pixel sequence 11,22,33,44,55,66,77,88; pix_last on 0x88.
4. num_words=3 with pix_ready toggling 1,0,0,1,... -> pix_data held while stalled, exactly 12 transfers, no duplicates or drops; with PIX_PREFETCH_EN and pix_ready=1, pix_valid continuous across word boundaries.
5. num_words=0 -> no iface_start, done pulse on cycle N+1, busy high for at most 1 cycle.
6. Second cmd_start (base 0x0100) while busy on a 2-word read from 0x0020 -> ignored; only addresses 0x0020 and 0x0021 read.

Source files
------------

// File: rtl/sram_pixel_reader.sv
// Block-read stage in front of sram_iface: one read per word, each word unpacked LSB-first onto a pixel stream.
// Define PIX_PREFETCH_EN to overlap the next word read with unpacking through a one-word holding register.
module sram_pixel_reader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int PIX_W     = 8,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [15:0]       cmd_num_words,
    output logic              busy,
    output logic              done,
    output logic              iface_start,
    output logic              iface_writemode,
    output logic [ADDR_W-1:0] iface_address,
    input  logic [DATA_W-1:0] iface_r_data,
    input  logic              iface_io_done,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);
    // state  | meaning
    // IDLE   | waiting for cmd_start
    // REQ    | issuing iface_start for the next word
    // WAIT   | read outstanding, word not yet available
    // UNPACK | streaming pixels of the current word
    localparam int PIX_PER_WORD = DATA_W / PIX_W;
    localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic ONE_PIX = (PIX_PER_WORD == 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, UNPACK} state_t;

    state_t state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx, iaddr_nx;
    logic [15:0] words_left, words_left_nx;
    logic [DATA_W-1:0] word, word_nx;
    logic [IDX_W-1:0] idx, idx_nx, idx_inc;
    logic [PIX_W-1:0] pdata_nx;
    logic busy_nx, done_nx, start_nx, pvalid_nx, plast_nx;
    logic xfer, last_word;
`ifdef PIX_PREFETCH_EN
    logic [15:0] req_left, req_left_nx;
    logic [DATA_W-1:0] hold, hold_nx;
    logic hold_valid, hold_valid_nx, pending, pending_nx;
`endif

    assign iface_writemode = 1'b0;
    assign xfer = pix_valid && pix_ready;
    assign last_word = (words_left == 16'd1);
    assign idx_inc = idx + IDX_W'(1);

    always_comb begin
        state_nx      = state;
        addr_nx       = addr;
        iaddr_nx      = iface_address;
        words_left_nx = words_left;
        word_nx       = word;
        idx_nx        = idx;
        pdata_nx      = pix_data;
        busy_nx       = busy;
        done_nx       = 1'b0;
        start_nx      = 1'b0;
        pvalid_nx     = pix_valid;
        plast_nx      = pix_last;
`ifdef PIX_PREFETCH_EN
        req_left_nx   = req_left;
        hold_nx       = hold;
        hold_valid_nx = hold_valid;
        pending_nx    = pending;
`endif
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    addr_nx       = cmd_base_addr;
                    words_left_nx = cmd_num_words;
`ifdef PIX_PREFETCH_EN
                    req_left_nx   = cmd_num_words;
`endif
                    if (cmd_num_words == 16'd0) begin
                        done_nx = 1'b1;
                    end else begin
                        busy_nx  = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                start_nx = 1'b1;
                iaddr_nx = addr;
                addr_nx  = addr + STEP;
`ifdef PIX_PREFETCH_EN
                req_left_nx = req_left - 16'd1;
`endif
                state_nx = WAIT;
            end
            WAIT: begin
                if (iface_io_done) begin
                    word_nx   = iface_r_data >> PIX_W;
                    pdata_nx  = iface_r_data[PIX_W-1:0];
                    idx_nx    = '0;
                    pvalid_nx = 1'b1;
                    plast_nx  = last_word && ONE_PIX;
`ifdef PIX_PREFETCH_EN
                    pending_nx = 1'b0;
`endif
                    state_nx  = UNPACK;
                end
            end
            UNPACK: begin
`ifdef PIX_PREFETCH_EN
                // Next word is fetched in the background; at most one read in flight.
                if (pending && iface_io_done) begin
                    hold_nx       = iface_r_data;
                    hold_valid_nx = 1'b1;
                    pending_nx    = 1'b0;
                end else if (req_left != 16'd0 && !hold_valid && !pending) begin
                    start_nx    = 1'b1;
                    iaddr_nx    = addr;
                    addr_nx     = addr + STEP;
                    req_left_nx = req_left - 16'd1;
                    pending_nx  = 1'b1;
                end
`endif
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        words_left_nx = words_left - 16'd1;
                        pvalid_nx     = 1'b0;
                        plast_nx      = 1'b0;
                        if (last_word) begin
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
`ifdef PIX_PREFETCH_EN
                        else if (hold_valid_nx) begin
                            // Held word (or one arriving this cycle) continues the stream with no bubble.
                            word_nx       = hold_nx >> PIX_W;
                            pdata_nx      = hold_nx[PIX_W-1:0];
                            idx_nx        = '0;
                            pvalid_nx     = 1'b1;
                            plast_nx      = (words_left == 16'd2) && ONE_PIX;
                            hold_valid_nx = 1'b0;
                        end else if (pending_nx) begin
                            state_nx = WAIT;
                        end
`endif
                        else begin
                            state_nx = REQ;
                        end
                    end else begin
                        idx_nx   = idx_inc;
                        pdata_nx = word[PIX_W-1:0];
                        word_nx  = word >> PIX_W;
                        plast_nx = last_word && (idx_inc == LAST_IDX);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state         <= IDLE;
            addr          <= '0;
            iface_address <= '0;
            words_left    <= '0;
            word          <= '0;
            idx           <= '0;
            pix_data      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            iface_start   <= 1'b0;
            pix_valid     <= 1'b0;
            pix_last      <= 1'b0;
`ifdef PIX_PREFETCH_EN
            req_left      <= '0;
            hold          <= '0;
            hold_valid    <= 1'b0;
            pending       <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            addr          <= addr_nx;
            iface_address <= iaddr_nx;
            words_left    <= words_left_nx;
            word          <= word_nx;
            idx           <= idx_nx;
            pix_data      <= pdata_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            iface_start   <= start_nx;
            pix_valid     <= pvalid_nx;
            pix_last      <= plast_nx;
`ifdef PIX_PREFETCH_EN
            req_left      <= req_left_nx;
            hold          <= hold_nx;
            hold_valid    <= hold_valid_nx;
            pending       <= pending_nx;
`endif
        end
    end
endmodule

// File: tb/tb_sram_pixel_reader.sv
// Randomized bench for sram_pixel_reader: an SRAM responder and pixel sink run in the background,
// each test compares the collected streams against an expected list built from address/word rules.
module tb_sram_pixel_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, cmd_start;
    logic [15:0] cmd_base_addr, cmd_num_words;
    logic        busy, done, iface_start, iface_writemode;
    logic [15:0] iface_address;
    logic [31:0] iface_r_data;
    logic        iface_io_done;
    logic [7:0]  pix_data;
    logic        pix_valid, pix_ready, pix_last;

    sram_pixel_reader dut (
        .clk(clk), .n_rst(n_rst), .cmd_start(cmd_start), .cmd_base_addr(cmd_base_addr),
        .cmd_num_words(cmd_num_words), .busy(busy), .done(done), .iface_start(iface_start),
        .iface_writemode(iface_writemode), .iface_address(iface_address),
        .iface_r_data(iface_r_data), .iface_io_done(iface_io_done), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
    );

    int checks = 0, passes = 0;

    // background observer state (written only by the background process)
    int cyc = 0, done_cnt = 0, start_cnt = 0, busy_cyc = 0, bubble_cnt = 0, stall_err = 0;
    int done_cyc = 0, last_xfer_cyc = 0, phase = 0, inject_seen = 0, delay = 0;
    logic busy_at_done = 1'b0;
    logic [15:0] addr_q[$];
    logic [7:0]  pix_q[$];
    logic        last_q[$];
    bit pend = 0, pv = 0, pr = 0, in_stream = 0;
    logic [15:0] paddr = '0;
    logic [7:0]  pd = '0;

    // test-side controls
    bit resp_en = 1;
    int ready_mode = 0;
    int inject_cnt = 0;
    logic [31:0] mem [int];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_pix[$];
    logic        exp_last[$];
    logic s1_start, s1_busy, s1_done, s2_start, s2_done;
    logic [15:0] s2_addr;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {a ^ 16'hC3A5, a};
    endfunction

    function automatic void build_expected(input logic [15:0] b, input int n);
        logic [31:0] w;
        logic [15:0] a;
        exp_addr.delete(); exp_pix.delete(); exp_last.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            exp_addr.push_back(a);
            w = word_at(a);
            for (int p = 0; p < 4; p++) begin
                exp_pix.push_back(w[8*p +: 8]);
                exp_last.push_back((i == n - 1) && (p == 3));
            end
        end
    endfunction

    function automatic int stream_diffs(input int p0, input int a0);
        int e = 0;
        for (int i = 0; i < exp_pix.size(); i++)
            if (p0 + i >= pix_q.size() || pix_q[p0+i] !== exp_pix[i] || last_q[p0+i] !== exp_last[i]) e++;
        for (int i = 0; i < exp_addr.size(); i++)
            if (a0 + i >= addr_q.size() || addr_q[a0+i] !== exp_addr[i]) e++;
        return e;
    endfunction

    // SRAM responder, pixel sink and stream monitor; acts 2 ns after each rising edge
    initial begin
        iface_io_done = 1'b0;
        iface_r_data  = '0;
        pix_ready     = 1'b0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            iface_io_done = 1'b0;
            if (inject_cnt != inject_seen) begin
                inject_seen   = inject_cnt;
                iface_io_done = 1'b1;
                iface_r_data  = 32'hDEADBEEF;
            end
            if (n_rst) begin
                pend = 0; pv = 0; in_stream = 0;
                continue;
            end
            if (pv && !pr && (!pix_valid || pix_data !== pd)) stall_err++;
            if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
            if (busy) busy_cyc++;
            if (in_stream && busy && !pix_valid) bubble_cnt++;
            if (iface_start) begin
                start_cnt++;
                addr_q.push_back(iface_address);
                if (resp_en) begin pend = 1; paddr = iface_address; delay = $urandom_range(0, 2); end
            end
            if (pend && !iface_io_done) begin
                if (delay == 0) begin
                    iface_io_done = 1'b1;
                    iface_r_data  = word_at(paddr);
                    pend = 0;
                end else delay--;
            end
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                default: begin pix_ready = (phase == 0); phase = (phase + 1) % 3; end
            endcase
            if (pix_valid && pix_ready) begin
                pix_q.push_back(pix_data);
                last_q.push_back(pix_last);
                last_xfer_cyc = cyc;
                in_stream = 1;
            end
            if (done) in_stream = 0;
            pv = pix_valid; pr = pix_ready; pd = pix_data;
        end
    end

    task automatic drive_cmd(input logic [15:0] b, input logic [15:0] n);
        @(negedge clk);
        cmd_base_addr = b; cmd_num_words = n; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        s1_start = iface_start; s1_busy = busy; s1_done = done;
        @(negedge clk);
        s2_start = iface_start; s2_addr = iface_address; s2_done = done;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != d0) begin ok = 1; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b1; cmd_start = 1'b0; cmd_base_addr = '0; cmd_num_words = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, iface_start, pix_valid, pix_last, iface_writemode} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, iface_start, pix_valid, pix_last, iface_writemode});
        else passes++;
        checks++;
        if (iface_address !== 16'h0) $display("FAIL reset_addr: got %h expected 0000", iface_address); else passes++;
        checks++;
        if (pix_data !== 8'h0) $display("FAIL reset_pix: got %h expected 00", pix_data); else passes++;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int d0, a0, p0, e; bit ok;
        mem[1] = 32'h000000AF;
        ready_mode = 0;
        d0 = done_cnt; a0 = addr_q.size(); p0 = pix_q.size();
        drive_cmd(16'h0001, 16'd1);
        checks++;
        if (s1_start !== 1'b0 || s1_busy !== 1'b1)
            $display("FAIL single_n1: start=%b busy=%b expected start=0 busy=1", s1_start, s1_busy);
        else passes++;
        checks++;
        if (s2_start !== 1'b1 || s2_addr !== 16'h0001)
            $display("FAIL single_req: start=%b addr=%h expected start=1 addr=0001", s2_start, s2_addr);
        else passes++;
        wait_done(d0, ok);
        checks++;
        if (!ok) $display("FAIL single_timeout: done not seen expected done"); else passes++;
        build_expected(16'h0001, 1);
        e = stream_diffs(p0, a0);
        checks++;
        if (e != 0 || pix_q.size() - p0 != 4 || addr_q.size() - a0 != 1)
            $display("FAIL single_stream: diffs=%0d pix=%0d reads=%0d expected 0/4/1", e, pix_q.size() - p0, addr_q.size() - a0);
        else passes++;
        checks++;
        if (done_cyc !== last_xfer_cyc + 1 || busy_at_done !== 1'b0)
            $display("FAIL single_done: done_cyc=%0d busy=%b expected %0d busy=0", done_cyc, busy_at_done, last_xfer_cyc + 1);
        else passes++;
    endtask

    task automatic test_wrap();
        int d0, a0, p0, e; bit ok;
        mem[16'hFFFF] = 32'h44332211;
        mem[0]        = 32'h88776655;
        ready_mode = 1;
        d0 = done_cnt; a0 = addr_q.size(); p0 = pix_q.size();
        drive_cmd(16'hFFFF, 16'd2);
        wait_done(d0, ok);
        build_expected(16'hFFFF, 2);
        e = stream_diffs(p0, a0);
        checks++;
        if (!ok || e != 0 || pix_q.size() - p0 != 8 || addr_q.size() - a0 != 2)
            $display("FAIL wrap_stream: ok=%b diffs=%0d pix=%0d reads=%0d expected 1/0/8/2", ok, e, pix_q.size() - p0, addr_q.size() - a0);
        else passes++;
        checks++;
        if (pix_q.size() >= p0 + 8 && (pix_q[p0+7] !== 8'h88 || last_q[p0+7] !== 1'b1))
            $display("FAIL wrap_last: pix=%h last=%b expected 88 last=1", pix_q[p0+7], last_q[p0+7]);
        else passes++;
    endtask

    task automatic test_stall();
        int d0, a0, p0, s0, b0, e; bit ok;
        logic [15:0] b;
        b = 16'($urandom);
        for (int i = 0; i < 3; i++) mem[int'(b + 16'(i))] = $urandom;
        ready_mode = 2;
        d0 = done_cnt; a0 = addr_q.size(); p0 = pix_q.size(); s0 = stall_err;
        drive_cmd(b, 16'd3);
        wait_done(d0, ok);
        build_expected(b, 3);
        e = stream_diffs(p0, a0);
        checks++;
        if (!ok || e != 0 || pix_q.size() - p0 != 12)
            $display("FAIL stall_stream: ok=%b diffs=%0d pix=%0d expected 1/0/12", ok, e, pix_q.size() - p0);
        else passes++;
        checks++;
        if (stall_err != s0) $display("FAIL stall_hold: violations=%0d expected 0", stall_err - s0); else passes++;

        ready_mode = 0;
        d0 = done_cnt; b0 = bubble_cnt;
        drive_cmd(b + 16'd7, 16'd3);
        wait_done(d0, ok);
        checks++;
`ifdef PIX_PREFETCH_EN
        if (!ok || bubble_cnt != b0) $display("FAIL stream_gap: ok=%b bubbles=%0d expected 0", ok, bubble_cnt - b0);
        else passes++;
`else
        if (!ok || bubble_cnt - b0 < 4) $display("FAIL stream_gap: ok=%b bubbles=%0d expected at least 4", ok, bubble_cnt - b0);
        else passes++;
`endif
    endtask

    task automatic test_zero();
        int d0, st0, b0; bit ok;
        d0 = done_cnt; st0 = start_cnt; b0 = busy_cyc;
        drive_cmd(16'h0033, 16'd0);
        checks++;
        if (s1_done !== 1'b1 || s2_done !== 1'b0)
            $display("FAIL zero_done: n1=%b n2=%b expected 1 then 0", s1_done, s2_done);
        else passes++;
        wait_done(d0, ok);
        checks++;
        if (start_cnt != st0 || done_cnt - d0 != 1 || busy_cyc - b0 > 1)
            $display("FAIL zero_side: starts=%0d dones=%0d busy=%0d expected 0/1/<=1", start_cnt - st0, done_cnt - d0, busy_cyc - b0);
        else passes++;
    endtask

    task automatic test_ignore();
        int d0, a0, p0, e; bit ok;
        ready_mode = 1;
        d0 = done_cnt; a0 = addr_q.size(); p0 = pix_q.size();
        drive_cmd(16'h0020, 16'd2);
        @(negedge clk);
        cmd_base_addr = 16'h0100; cmd_num_words = 16'd5; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(d0, ok);
        repeat (10) @(negedge clk);
        build_expected(16'h0020, 2);
        e = stream_diffs(p0, a0);
        checks++;
        if (!ok || e != 0 || addr_q.size() - a0 != 2 || pix_q.size() - p0 != 8)
            $display("FAIL ignore_cmd: ok=%b diffs=%0d reads=%0d pix=%0d expected 1/0/2/8", ok, e, addr_q.size() - a0, pix_q.size() - p0);
        else passes++;
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0)
            $display("FAIL ignore_done: dones=%0d busy=%b expected 1 busy=0", done_cnt - d0, busy);
        else passes++;
    endtask

    task automatic test_reset_midway();
        int d0, p0;
        resp_en = 0;
        ready_mode = 0;
        d0 = done_cnt; p0 = pix_q.size();
        drive_cmd(16'h0010, 16'd1);
        checks++;
        if (s2_addr !== 16'h0010 || busy !== 1'b1)
            $display("FAIL midrst_wait: addr=%h busy=%b expected 0010 busy=1", s2_addr, busy);
        else passes++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, iface_start, pix_valid, pix_last} !== 5'b0 || iface_address !== 16'h0 || pix_data !== 8'h0)
            $display("FAIL midrst_out: ctrl=%b addr=%h pix=%h expected all 0",
                     {busy, done, iface_start, pix_valid, pix_last}, iface_address, pix_data);
        else passes++;
        n_rst = 1'b0;
        inject_cnt++;
        repeat (6) @(negedge clk);
        checks++;
        if (pix_q.size() != p0 || done_cnt != d0 || busy !== 1'b0 || pix_valid !== 1'b0)
            $display("FAIL midrst_late: pix=%0d dones=%0d busy=%b valid=%b expected 0/0/0/0",
                     pix_q.size() - p0, done_cnt - d0, busy, pix_valid);
        else passes++;
        resp_en = 1;
    endtask

    task automatic test_random();
        int d0, a0, p0, s0, e, n; bit ok;
        logic [15:0] b;
        for (int k = 0; k < 8; k++) begin
            b = 16'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) mem[int'(b + 16'(i))] = $urandom;
            ready_mode = $urandom_range(0, 2);
            d0 = done_cnt; a0 = addr_q.size(); p0 = pix_q.size(); s0 = stall_err;
            drive_cmd(b, 16'(n));
            wait_done(d0, ok);
            build_expected(b, n);
            e = stream_diffs(p0, a0);
            checks++;
            if (!ok || e != 0 || pix_q.size() - p0 != 4 * n || addr_q.size() - a0 != n || stall_err != s0)
                $display("FAIL random_%0d: ok=%b diffs=%0d pix=%0d reads=%0d stalls=%0d expected 1/0/%0d/%0d/0",
                         k, ok, e, pix_q.size() - p0, addr_q.size() - a0, stall_err - s0, 4 * n, n);
            else passes++;
            checks++;
            if (done_cyc !== last_xfer_cyc + 1 || busy_at_done !== 1'b0)
                $display("FAIL random_done_%0d: done_cyc=%0d busy=%b expected %0d busy=0", k, done_cyc, busy_at_done, last_xfer_cyc + 1);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_zero();
        test_ignore();
        test_reset_midway();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
